// File: rtl/wb_stage_pipelined.sv
// Write-back stage: selects/format result, drives RF write port, forwarding tap, retire counter.
// Latency: one cycle from input sample to registered outputs.
// Backpressure: stall holds every register; flush kills the incoming instruction even under stall.
module wb_stage_pipelined #(
    parameter int XLEN   = 32,
    parameter int CNT_W  = 64,
    parameter int PC_INC = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic [XLEN-1:0]  alu_result,
    input  logic [XLEN-1:0]  mem_rdata,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  csr_rdata,
    input  logic [1:0]       data_select,
    input  logic [2:0]       load_funct3,
    input  logic [2:0]       addr_lsb,
    input  logic [4:0]       rd_addr,
    input  logic             reg_write,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [XLEN-1:0]  rf_wdata,
    output logic             wb_valid,
    output logic             fwd_valid,
    output logic [4:0]       fwd_addr,
    output logic [XLEN-1:0]  fwd_data,
    output logic [CNT_W-1:0] instret
);

    logic [2:0]      byte_off;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] link_data;
    logic [XLEN-1:0] sel_data;
    logic            lsb_unused;

    // Only a 64-bit datapath has eight byte lanes, so bit 2 of the offset is ignored for 32-bit.
    assign lsb_unused = addr_lsb[2];

    // Align the load word so the addressed byte sits in lane 0; misaligned offsets pass through as-is.
    always_comb begin
        byte_off = (XLEN == 64) ? addr_lsb : {1'b0, addr_lsb[1:0]};
        shifted  = mem_rdata >> {byte_off, 3'b000};
    end

    // Sign/zero extension per load type; LW on a 32-bit datapath is just the shifted word.
    always_comb begin
        load_data = shifted;
        case (load_funct3)
            3'b000:  load_data = XLEN'($signed(shifted[7:0]));
            3'b001:  load_data = XLEN'($signed(shifted[15:0]));
            3'b010:  load_data = XLEN'($signed(shifted[31:0]));
            3'b100:  load_data = XLEN'(shifted[7:0]);
            3'b101:  load_data = XLEN'(shifted[15:0]);
            3'b110:  load_data = XLEN'(shifted[31:0]);
            default: load_data = shifted;
        endcase
    end

    // Result source mux; link address wraps modulo 2^XLEN.
    always_comb begin
        link_data = pc + XLEN'(PC_INC);
        case (data_select)
            2'b00:   sel_data = alu_result;
            2'b01:   sel_data = load_data;
            2'b10:   sel_data = link_data;
            default: sel_data = csr_rdata;
        endcase
    end

    // Valid/write-enable: flush wins over stall, stall holds, otherwise accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            rf_we    <= 1'b0;
        end else if (flush) begin
            wb_valid <= 1'b0;
            rf_we    <= 1'b0;
        end else if (!stall) begin
            wb_valid <= in_valid;
            rf_we    <= in_valid & reg_write & (rd_addr != 5'd0);
        end
    end

    // Address/data follow the accept path; their value after a flush is irrelevant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_waddr <= 5'd0;
            rf_wdata <= '0;
        end else if (!stall) begin
            rf_waddr <= rd_addr;
            rf_wdata <= sel_data;
        end
    end

    // An instruction retires when it leaves the stage, regardless of whether it writes rd.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret <= '0;
        end else if (wb_valid && !stall) begin
            instret <= instret + CNT_W'(1);
        end
    end

    assign fwd_valid = rf_we;
    assign fwd_addr  = rf_waddr;
    assign fwd_data  = rf_wdata;

endmodule
